// File: rtl/lock_pkg.sv
// ---------------------------------------------------------------------------
// lock_pkg
// Shared types and helpers for the combination-lock supervisor.
//   state_t      : supervisor FSM states
//   disp_mode_t  : Moore display-mode code sent to the 7-segment decoder
//   code_nibble  : selects digit <idx> from a packed code vector, where the
//                  first-entered digit sits in the most significant nibble
// ---------------------------------------------------------------------------
package lock_pkg;

  localparam int unsigned    DIGIT_W    = 4;
  localparam logic [3:0]     DIGIT_MAX  = 4'd9;
  // Widest code vector the helper accepts (7 digits, as digit_idx is 3 bits).
  localparam int unsigned    CODE_MAX_W = 28;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_CLOSED  = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROG    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    DM_DIGIT  = 3'd0,
    DM_OPEN   = 3'd1,
    DM_CLOSED = 3'd2,
    DM_LOCKED = 3'd3,
    DM_PROG   = 3'd4
  } disp_mode_t;

  // Digit idx of a code_len-digit code; digit 0 is the MS nibble.
  function automatic logic [3:0] code_nibble(
    input logic [CODE_MAX_W-1:0] code,
    input logic [2:0]            idx,
    input logic [2:0]            code_len
  );
    logic [2:0]            pos;
    logic [CODE_MAX_W-1:0] shifted;
    pos     = code_len - 3'd1 - idx;
    shifted = code >> {pos, 2'b00};
    return shifted[3:0];
  endfunction

  // Display mode is a pure decode of the FSM state.
  function automatic disp_mode_t state_to_disp(input state_t st);
    disp_mode_t dm;
    case (st)
      ST_ENTRY:   dm = DM_DIGIT;
      ST_OPEN:    dm = DM_OPEN;
      ST_CLOSED:  dm = DM_CLOSED;
      ST_LOCKOUT: dm = DM_LOCKED;
      ST_PROG:    dm = DM_PROG;
      default:    dm = DM_DIGIT;
    endcase
    return dm;
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// ---------------------------------------------------------------------------
// lockout_timer
// Down-counter timing the lockout dwell.
//   clk, reset   : clock, asynchronous active-low reset
//   i_load       : load i_load_val (has priority over i_en)
//   i_load_val   : value loaded when entering lockout
//   i_en         : decrement by one per cycle, saturating at zero
//   o_count      : current count (registered)
//   o_one        : count reads 1, i.e. this is the last lockout cycle
// ---------------------------------------------------------------------------
module lockout_timer #(
  parameter int unsigned LOCK_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [LOCK_W-1:0] i_load_val,
  input  logic              i_en,
  output logic [LOCK_W-1:0] o_count,
  output logic              o_one
);

  logic [LOCK_W-1:0] r_count;

  // Load / decrement the remaining-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - LOCK_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
  assign o_one   = (r_count == LOCK_W'(1));

endmodule

// File: rtl/lock_supervisor.sv
// ---------------------------------------------------------------------------
// lock_supervisor
// Sequencing controller for the combination lock: holds the BCD code, walks
// digit entry, judges OPEN/CLOSED, counts consecutive failures, enforces a
// timed lockout and supports reprogramming the code from OPEN.
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   enter        : one-cycle strobe, digit valid in the same cycle
//   digit        : entered value (10..15 invalid)
//   prog_req     : level, sampled on enter while OPEN
//   relock       : one-cycle strobe back to entry
//   disp_mode    : 0 DIGIT, 1 OPEN, 2 CLOSED, 3 LOCKED, 4 PROG (registered)
//   digit_idx    : index of the next digit to be entered (registered)
//   fail_cnt     : consecutive failed attempts (registered)
//   lockout_left : remaining lockout cycles, 0 outside lockout (registered)
// ---------------------------------------------------------------------------
module lock_supervisor
  import lock_pkg::*;
#(
  parameter int unsigned               CODE_LEN       = 6,
  parameter logic [4*CODE_LEN-1:0]     DEFAULT_CODE   = 24'h722297,
  parameter int unsigned               MAX_FAIL       = 3,
  parameter int unsigned               LOCKOUT_CYCLES = 1000,
  parameter int unsigned               LOCK_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enter,
  input  logic [3:0]        digit,
  input  logic              prog_req,
  input  logic              relock,
  output logic [2:0]        disp_mode,
  output logic [2:0]        digit_idx,
  output logic [1:0]        fail_cnt,
  output logic [LOCK_W-1:0] lockout_left
);

  localparam int unsigned CODE_W     = DIGIT_W * CODE_LEN;
  localparam logic [2:0]  LAST_IDX   = 3'(CODE_LEN - 1);
  localparam logic [2:0]  CODE_LEN_L = 3'(CODE_LEN);
  // fail_cnt+1 < MAX_FAIL  <=>  fail_cnt < MAX_FAIL-1
  localparam logic [1:0]  FAIL_LIMIT = 2'(MAX_FAIL - 1);

  state_t             r_state;
  disp_mode_t         r_disp_mode;
  logic [2:0]         r_idx;
  logic               r_mismatch;
  logic [1:0]         r_fail_cnt;
  logic [CODE_W-1:0]  r_code;
  logic [CODE_W-1:0]  r_shadow;

  state_t             w_state_nxt;
  logic [2:0]         w_idx_nxt;
  logic               w_mm_nxt;
  logic [1:0]         w_fail_nxt;
  logic [CODE_W-1:0]  w_code_nxt;
  logic [CODE_W-1:0]  w_shadow_nxt;
  logic [CODE_W-1:0]  w_shadow_shift;
  logic               w_load;
  logic               w_timer_one;
  logic               w_digit_bad;
  logic               w_mm_now;
  logic               w_last;
  logic               w_state_chg;
  logic [3:0]         w_code_digit;

  // New programmed digits shift in at the LS end, so after CODE_LEN digits
  // the first one entered ends up in the MS nibble.
  assign w_shadow_shift = (r_shadow << DIGIT_W) | CODE_W'(digit);
  assign w_code_digit   = code_nibble(CODE_MAX_W'(r_code), r_idx, CODE_LEN_L);
  assign w_digit_bad    = (digit > DIGIT_MAX);
  assign w_mm_now       = r_mismatch | w_digit_bad | (digit != w_code_digit);
  assign w_last         = (r_idx == LAST_IDX);
  assign w_state_chg    = (w_state_nxt != r_state);

  lockout_timer #(
    .LOCK_W (LOCK_W)
  ) u_lockout_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (LOCK_W'(LOCKOUT_CYCLES)),
    .i_en       (r_state == ST_LOCKOUT),
    .o_count    (lockout_left),
    .o_one      (w_timer_one)
  );

  // Next-state and datapath decisions; relock always beats enter.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_mm_nxt     = r_mismatch;
    w_fail_nxt   = r_fail_cnt;
    w_code_nxt   = r_code;
    w_shadow_nxt = r_shadow;
    w_load       = 1'b0;
    case (r_state)
      ST_ENTRY: begin
        if (relock) begin
          w_idx_nxt = 3'd0;
          w_mm_nxt  = 1'b0;
        end else if (enter) begin
          if (w_last) begin
            if (!w_mm_now) begin
              w_state_nxt = ST_OPEN;
              w_fail_nxt  = 2'd0;
            end else if (r_fail_cnt < FAIL_LIMIT) begin
              w_state_nxt = ST_CLOSED;
              w_fail_nxt  = r_fail_cnt + 2'd1;
            end else begin
              w_state_nxt = ST_LOCKOUT;
              w_fail_nxt  = r_fail_cnt + 2'd1;
              w_load      = 1'b1;
            end
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_mm_nxt  = w_mm_now;
          end
        end else begin
          w_idx_nxt = r_idx;
        end
      end
      ST_CLOSED: begin
        if (relock) begin
          w_state_nxt = ST_ENTRY;
        end else begin
          w_state_nxt = ST_CLOSED;
        end
      end
      ST_OPEN: begin
        if (relock) begin
          w_state_nxt = ST_ENTRY;
        end else if (enter && prog_req) begin
          w_state_nxt = ST_PROG;
        end else begin
          w_state_nxt = ST_OPEN;
        end
      end
      ST_PROG: begin
        if (relock) begin
          w_state_nxt = ST_ENTRY;
        end else if (enter) begin
          if (w_digit_bad) begin
            w_state_nxt = ST_OPEN;
          end else if (w_last) begin
            w_code_nxt  = w_shadow_shift;
            w_state_nxt = ST_OPEN;
          end else begin
            w_shadow_nxt = w_shadow_shift;
            w_idx_nxt    = r_idx + 3'd1;
          end
        end else begin
          w_state_nxt = ST_PROG;
        end
      end
      ST_LOCKOUT: begin
        if (w_timer_one) begin
          w_state_nxt = ST_ENTRY;
          w_fail_nxt  = 2'd0;
        end else begin
          w_state_nxt = ST_LOCKOUT;
        end
      end
      default: begin
        w_state_nxt = ST_ENTRY;
      end
    endcase
  end

  // FSM state, entry progress, code storage and registered Moore outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_ENTRY;
      r_disp_mode <= DM_DIGIT;
      r_idx       <= 3'd0;
      r_mismatch  <= 1'b0;
      r_fail_cnt  <= 2'd0;
      r_code      <= DEFAULT_CODE;
      r_shadow    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_disp_mode <= state_to_disp(w_state_nxt);
      // Any state change restarts digit progress.
      r_idx       <= w_state_chg ? 3'd0 : w_idx_nxt;
      r_mismatch  <= w_state_chg ? 1'b0 : w_mm_nxt;
      r_fail_cnt  <= w_fail_nxt;
      r_code      <= w_code_nxt;
      r_shadow    <= w_shadow_nxt;
    end
  end

  assign disp_mode = r_disp_mode;
  assign digit_idx = r_idx;
  assign fail_cnt  = r_fail_cnt;

endmodule
